ex_wb_pipe: RTL

EX_WB_PIPE -- requirements
Module: ex_wb_pipe

---
 rtl/risc_pkg.sv | 21 ++
 rtl/wb_fifo2.sv | 87 ++++++++
 rtl/ex_wb_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared datapath widths and the writeback entry format for the EX->WB path.
package risc_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // One buffered execute result awaiting register-file writeback.
  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
  } wb_entry_t;

  // Occupancy of the two-entry writeback buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order buffer between execute and writeback.
// The head slot always holds the oldest entry; the tail slot is only live when full.
module wb_fifo2
  import risc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush_i,
  input  logic      in_valid_i,
  input  wb_entry_t push_entry_i,
  input  logic      out_ready_i,
  output logic      in_ready_o,
  output logic      head_valid_o,
  output logic      tail_valid_o,
  output wb_entry_t head_o,
  output wb_entry_t tail_o,
  output logic      pop_o
);

  occ_e      state_q, state_d;
  wb_entry_t head_q, head_d;
  wb_entry_t tail_q, tail_d;
  logic      push;
  logic      pop;

  // Occupancy register and entry storage; reset clears the slots so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next occupancy: flush empties the buffer regardless of any handshake.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: if (push) state_d = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      state_d = OCC_FULL;
          else if (!push && pop) state_d = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // Handshake qualifiers and slot visibility, all derived from registered occupancy.
  always_comb begin
    in_ready_o   = (state_q != OCC_FULL);
    head_valid_o = (state_q != OCC_EMPTY);
    tail_valid_o = (state_q == OCC_FULL);
    push         = in_valid_i && in_ready_o;
    pop          = out_ready_i && head_valid_o;
    pop_o        = pop && !flush_i;
    head_o       = head_q;
    tail_o       = tail_q;
  end

  // Slot updates: a simultaneous push/pop at one entry writes straight into the head,
  // and a pop while full promotes the tail. An empty buffer keeps its stale head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (!flush_i) begin
      unique case (state_q)
        OCC_EMPTY: if (push) head_d = push_entry_i;
        OCC_ONE: begin
          if (push && pop) head_d = push_entry_i;
          else if (push)   tail_d = push_entry_i;
        end
        OCC_FULL:  if (pop) head_d = tail_q;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/ex_wb_pipe.sv
// Execute-to-writeback pipeline buffer with register forwarding and a retire counter.
module ex_wb_pipe #(
  parameter int unsigned DATA_W     = risc_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = risc_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wen,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wen,
  input  logic [REG_ADDR_W-1:0] fwd_rs,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [31:0]           retire_count
);

  import risc_pkg::*;

  wb_entry_t   push_entry;
  wb_entry_t   head;
  wb_entry_t   tail;
  logic        head_valid;
  logic        tail_valid;
  logic        pop;
  logic [31:0] retire_q, retire_d;

  // Build the captured entry; writes to x0 are dropped here so nothing downstream sees them.
  always_comb begin
    push_entry        = '0;
    push_entry.result = in_result;
    push_entry.rd     = in_rd;
    push_entry.wen    = in_wen && (in_rd != '0);
  end

  wb_fifo2 u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .push_entry_i (push_entry),
    .out_ready_i  (out_ready),
    .in_ready_o   (in_ready),
    .head_valid_o (head_valid),
    .tail_valid_o (tail_valid),
    .head_o       (head),
    .tail_o       (tail),
    .pop_o        (pop)
  );

  // Writeback port: data holds its last value when empty, but the enable is gated off.
  always_comb begin
    out_valid  = head_valid;
    out_result = head.result;
    out_rd     = head.rd;
    out_wen    = head.wen && head_valid;
  end

  // Forwarding lookup: the tail is the younger entry whenever it is live, so check it first.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != '0) begin
      if (tail_valid && tail.wen && (tail.rd == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = tail.result;
      end else if (head_valid && head.wen && (head.rd == fwd_rs)) begin
        fwd_hit  = 1'b1;
        fwd_data = head.result;
      end
    end
  end

  // Retire count increment; wraps naturally at 32 bits.
  always_comb begin
    retire_d     = retire_q + 32'd1;
    retire_count = retire_q;
  end

  // Retire counter: pop already excludes flush cycles, reset takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else if (pop) begin
      retire_q <= retire_d;
    end
  end

endmodule
